// File: rtl/cpu_press_scheduler.sv
// cpu_press_scheduler: sequencer for the computer tug-of-war player.
// Steps a 10-bit XNOR Fibonacci LFSR once per tick, samples the comparator
// decision on the freshly stepped value, and issues a one-cycle press pulse
// followed by a cooldown of COOLDOWN ticks.
module cpu_press_scheduler #(
    parameter int unsigned TICK_DIV = 50000,
    parameter int unsigned COOLDOWN = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       win,
    input  logic       press_req,
    output logic [9:0] comp,
    output logic       press,
    output logic       busy
);

    localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned CW = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_SAMPLE,
        S_PRESS,
        S_COOLDOWN
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [TW-1:0]   tick_cnt;
    logic [CW-1:0]   cool_cnt;
    logic            tick_done;
    logic            cool_done;
    logic            run;
    logic            step;

    assign tick_done = (tick_cnt == TW'(TICK_DIV - 1));
    assign cool_done = (cool_cnt == CW'(COOLDOWN - 1));
    assign run       = enable && !win;

    // Next-state decode; abort back to IDLE overrides every other transition.
    always_comb begin
        next_state = state;
        step       = 1'b0;
        case (state)
            S_IDLE:     if (run) next_state = S_WAIT;
            S_WAIT:     if (tick_done) next_state = S_SAMPLE;
            S_SAMPLE:   next_state = press_req ? S_PRESS : S_WAIT;
            S_PRESS:    next_state = S_COOLDOWN;
            S_COOLDOWN: if (tick_done && cool_done) next_state = S_WAIT;
            default:    next_state = S_IDLE;
        endcase
        if (state != S_IDLE && !run) begin
            next_state = S_IDLE;
        end
        step = (state == S_WAIT) && (next_state == S_SAMPLE);
    end

    // State, LFSR, counters and registered decodes of the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            comp     <= '0;
            press    <= 1'b0;
            busy     <= 1'b0;
            tick_cnt <= '0;
            cool_cnt <= '0;
        end else begin
            state <= next_state;
            press <= (next_state == S_PRESS);
            busy  <= (next_state != S_IDLE);
            if (step) begin
                comp <= {comp[8:0], ~(comp[9] ^ comp[6])};
            end
            if (next_state != state || next_state == S_IDLE) begin
                tick_cnt <= '0;
                cool_cnt <= '0;
            end else if (state == S_WAIT || state == S_COOLDOWN) begin
                if (tick_done) begin
                    tick_cnt <= '0;
                    if (state == S_COOLDOWN) begin
                        cool_cnt <= cool_cnt + CW'(1);
                    end
                end else begin
                    tick_cnt <= tick_cnt + TW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_cpu_press_scheduler.sv
// Testbench for cpu_press_scheduler: directed timeline checks plus a
// randomized run checked by an event scoreboard fed from a deadline-based
// behavioural model.
module tb_cpu_press_scheduler;

    localparam int unsigned TD = 4;
    localparam int unsigned CD = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       win = 1'b0;
    logic [8:0] sw = '0;
    logic       press_req;
    logic [9:0] comp;
    logic       press;
    logic       busy;

    int errors = 0;
    int checks = 0;

    cpu_press_scheduler #(.TICK_DIV(TD), .COOLDOWN(CD)) dut (
        .clk(clk), .reset(reset), .enable(enable), .win(win),
        .press_req(press_req), .comp(comp), .press(press), .busy(busy)
    );

    always #5 clk = ~clk;

    // Comparator stand-in: values with bit 9 set are masked, otherwise press when below the switches.
    function automatic logic cmp(input logic [9:0] c, input logic [8:0] s);
        return !c[9] && (c[8:0] < s);
    endfunction

    assign press_req = cmp(comp, sw);

    function automatic logic [9:0] lfsr_next(input logic [9:0] v);
        return {v[8:0], ~(v[9] ^ v[6])};
    endfunction

    // ---------------- reference model (absolute-time deadlines) ----------------
    typedef enum {M_OFF, M_WAIT, M_SAMPLE, M_PRESS, M_COOL} mphase_t;
    typedef struct {
        int         cyc;
        bit         is_press;
        logic [9:0] val;
    } ev_t;

    ev_t        evq[$];
    int         cyc = 0;
    mphase_t    ph = M_OFF;
    int         phase_end = 0;
    logic [9:0] m_comp = '0;
    bit         m_busy = 1'b0;

    initial begin : model
        logic       r, e, w;
        logic [8:0] s;
        forever begin
            @(negedge clk);
            r = reset; e = enable; w = win; s = sw;
            @(posedge clk);
            cyc++;
            if (r) begin
                if (m_comp != 10'h000) evq.push_back('{cyc: cyc, is_press: 1'b0, val: 10'h000});
                m_comp = '0;
                ph = M_OFF;
            end else if (ph == M_OFF) begin
                if (e && !w) begin ph = M_WAIT; phase_end = cyc + TD - 1; end
            end else if (!e || w) begin
                ph = M_OFF;
            end else begin
                case (ph)
                    M_WAIT: if (cyc - 1 == phase_end) begin
                        m_comp = lfsr_next(m_comp);
                        evq.push_back('{cyc: cyc, is_press: 1'b0, val: m_comp});
                        ph = M_SAMPLE;
                    end
                    M_SAMPLE: if (cmp(m_comp, s)) begin
                        ph = M_PRESS;
                        evq.push_back('{cyc: cyc, is_press: 1'b1, val: m_comp});
                    end else begin
                        ph = M_WAIT; phase_end = cyc + TD - 1;
                    end
                    M_PRESS: begin ph = M_COOL; phase_end = cyc + CD * TD - 1; end
                    M_COOL: if (cyc - 1 == phase_end) begin ph = M_WAIT; phase_end = cyc + TD - 1; end
                    default: ph = M_OFF;
                endcase
            end
            m_busy = (ph != M_OFF);
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin : monitor
        logic [9:0] prev;
        ev_t        ev;
        @(posedge clk); @(posedge clk); @(negedge clk);
        prev = comp;
        forever begin
            @(negedge clk);
            while (evq.size() > 0 && evq[0].cyc < cyc) begin
                checks++; errors++;
                $display("FAIL missing_event at cyc %0d: expected press=%0b comp=%h, DUT never showed it", evq[0].cyc, evq[0].is_press, evq[0].val);
                void'(evq.pop_front());
            end
            if (comp !== prev) begin
                checks++;
                if (evq.size() == 0) begin
                    errors++;
                    $display("FAIL comp_change cyc %0d: got comp=%h, expected no change", cyc, comp);
                end else begin
                    ev = evq.pop_front();
                    if (ev.is_press || ev.cyc != cyc || ev.val !== comp) begin
                        errors++;
                        $display("FAIL comp_change cyc %0d: got comp=%h, expected comp=%h press_ev=%0b at cyc %0d", cyc, comp, ev.val, ev.is_press, ev.cyc);
                    end
                end
            end
            if (press !== 1'b0) begin
                checks++;
                if (evq.size() == 0) begin
                    errors++;
                    $display("FAIL press_event cyc %0d: got press=%b, expected no press", cyc, press);
                end else begin
                    ev = evq.pop_front();
                    if (!ev.is_press || ev.cyc != cyc || press !== 1'b1) begin
                        errors++;
                        $display("FAIL press_event cyc %0d: got press=%b, expected press_ev=%0b at cyc %0d", cyc, press, ev.is_press, ev.cyc);
                    end
                end
            end
            checks++;
            if (busy !== m_busy) begin
                errors++;
                $display("FAIL busy cyc %0d: got %b, expected %b", cyc, busy, m_busy);
            end
            prev = comp;
        end
    end

    // ---------------- stimulus and directed checks ----------------
    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    // Reset, then leave the bench in cycle 0 (IDLE with enable high).
    task automatic start(input logic [8:0] swv);
        reset = 1'b1; enable = 1'b0; win = 1'b0;
        tick(2);
        sw = swv; reset = 1'b0; enable = 1'b1;
    endtask

    task automatic press_timeline(input string tag);
        for (int k = 0; k <= 21; k++) begin
            if (k == 0)  chk({tag, "_busy0"}, int'(busy), 0);
            if (k == 1)  chk({tag, "_busy1"}, int'(busy), 1);
            if (k == 5)  chk({tag, "_comp5"}, int'(comp), 'h001);
            if (k == 20) chk({tag, "_comp20"}, int'(comp), 'h003);
            chk($sformatf("%s_press_c%0d", tag, k), int'(press), (k == 6 || k == 20) ? 1 : 0);
            tick(1);
        end
    endtask

    initial begin : stim
        int seen[1024];
        int steps, bad;
        logic [9:0] prev;

        // Always-press timeline
        start(9'h1FF);
        press_timeline("always");

        // Never-press stepping
        start(9'h000);
        for (int k = 0; k <= 40; k++) begin
            if (k == 5)  chk("never_comp5",  int'(comp), 'h001);
            if (k == 10) chk("never_comp10", int'(comp), 'h003);
            if (k == 15) chk("never_comp15", int'(comp), 'h007);
            if (k == 20) chk("never_comp20", int'(comp), 'h00F);
            if (k == 40) chk("never_comp40", int'(comp), 'h0FE);
            if (k % 5 == 0) chk("never_press", int'(press), 0);
            tick(1);
        end

        // Win abort during the first SAMPLE
        start(9'h1FF);
        tick(5);
        win = 1'b1;
        tick(1);
        chk("win_busy6", int'(busy), 0);
        for (int k = 0; k < 8; k++) begin
            chk("win_press", int'(press), 0);
            chk("win_comp_hold", int'(comp), 'h001);
            tick(1);
        end
        win = 1'b0; enable = 1'b0;

        // Reset mid-cooldown, then timeline repeats from release
        start(9'h1FF);
        tick(10);
        reset = 1'b1;
        tick(1);
        chk("rst_comp", int'(comp), 0);
        chk("rst_press", int'(press), 0);
        chk("rst_busy", int'(busy), 0);
        reset = 1'b0;
        press_timeline("after_rst");

        // Enable glitch in WAIT
        start(9'h000);
        tick(3);
        enable = 1'b0;
        tick(1);
        chk("glitch_busy", int'(busy), 0);
        enable = 1'b1;
        tick(4);
        chk("glitch_comp_before", int'(comp), 'h000);
        tick(1);
        chk("glitch_comp_first", int'(comp), 'h001);
        tick(5);
        chk("glitch_comp_second", int'(comp), 'h003);

        // Full LFSR period
        start(9'h000);
        foreach (seen[i]) seen[i] = 0;
        steps = 0; prev = 10'h000;
        for (int k = 0; k < 1023 * 5 + 10 && steps < 1023; k++) begin
            tick(1);
            if (comp != prev) begin seen[comp]++; steps++; prev = comp; end
        end
        chk("period_steps", steps, 1023);
        chk("period_return", int'(comp), 'h000);
        chk("period_lockup", seen[1023], 0);
        bad = 0;
        for (int v = 0; v < 1023; v++) if (seen[v] != 1) bad++;
        chk("period_unique", bad, 0);

        // Randomized run checked by the scoreboard
        start(9'($urandom));
        for (int k = 0; k < 4000; k++) begin
            int unsigned r;
            r = $urandom_range(0, 99);
            if (r < 3)       enable = ~enable;
            else if (r < 5)  win = ~win;
            else if (r < 8)  sw = 9'($urandom);
            reset = ($urandom_range(0, 249) == 0);
            tick(1);
        end
        reset = 1'b0; enable = 1'b0; win = 1'b0;
        tick(5);
        chk("scoreboard_drained", evq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
